// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and flag bit positions shared by the ALU pipeline
package alu_pkg;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath with optional unsigned saturation
module alu_core import alu_pkg::*; #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    localparam int SW = $clog2(WIDTH);
    logic [SW-1:0]    sh;
    logic [WIDTH:0]   sum, diff, shl, shr;
    logic [WIDTH-1:0] raw;
    logic             c, v;
    assign sh   = op_b[SW-1:0];
    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};
    assign shl  = {1'b0, op_a} << sh;
    assign shr  = {op_a, 1'b0} >> sh;
    // Select result and derive flags; the extra bit of shl/shr holds the last bit shifted out
    always_comb begin
        case (alu_op)
            OP_ADD:  raw = sum[WIDTH-1:0];
            OP_SUB:  raw = diff[WIDTH-1:0];
            OP_AND:  raw = op_a & op_b;
            OP_OR:   raw = op_a | op_b;
            OP_XOR:  raw = op_a ^ op_b;
            OP_NOT:  raw = ~op_a;
            OP_SHL:  raw = shl[WIDTH-1:0];
            default: raw = shr[WIDTH:1];
        endcase
        c = (alu_op == OP_ADD) ? sum[WIDTH] :
            (alu_op == OP_SUB) ? diff[WIDTH] :
            (alu_op == OP_SHL) ? shl[WIDTH] :
            (alu_op == OP_SHR) ? shr[0] : 1'b0;
        v = (alu_op == OP_ADD) ? (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]) :
            (alu_op == OP_SUB) ? (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]) : 1'b0;
        result = (SAT && c && alu_op == OP_ADD) ? '1 :
                 (SAT && c && alu_op == OP_SUB) ? '0 : raw;
        flags         = '0;
        flags[FLAG_C] = c;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_V] = v;
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline with sticky overflow indicator
module alu_pipe import alu_pkg::*; #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);
    logic             s1_valid, s2_adv, s2_arith;
    logic [WIDTH-1:0] s1_a, s1_b, core_result;
    logic [2:0]       s1_op;
    logic [3:0]       core_flags;
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    // Stage 1: take a new operation whenever the stage is empty or moving on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= op_a;
                s1_b  <= op_b;
                s1_op <= alu_op;
            end
        end
    end
    alu_core #(.WIDTH(WIDTH), .SAT(SAT)) u_core (
        .op_a   (s1_a),
        .op_b   (s1_b),
        .alu_op (s1_op),
        .result (core_result),
        .flags  (core_flags)
    );
    // Stage 2: register result and flags, holding them while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            s2_arith  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result   <= core_result;
                flags    <= core_flags;
                s2_arith <= (s1_op == OP_ADD) || (s1_op == OP_SUB);
            end
        end
    end
    // Sticky overflow: set on consumption of V or arithmetic carry, clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_sticky <= 1'b0;
        else if (clr_sticky)
            ovf_sticky <= 1'b0;
        else if (out_valid && out_ready && (flags[FLAG_V] || (flags[FLAG_C] && s2_arith)))
            ovf_sticky <= 1'b1;
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random scoreboard checks of alu_pipe with SAT=0 and SAT=1
module tb_alu_pipe;
    import alu_pkg::*;
    logic        clk, rst_n, in_valid, out_ready, clr_sticky;
    logic [7:0]  op_a, op_b;
    logic [2:0]  alu_op;
    logic        in_ready0, in_ready1, out_valid0, out_valid1, sticky0, sticky1;
    logic [7:0]  result0, result1;
    logic [3:0]  flags0, flags1;
    int          total, bad, acc, idx, n;
    logic [23:0] sb[$];
    logic [7:0]  held_r, ra, rb;
    logic [3:0]  held_f;
    logic [2:0]  rop;
    logic [7:0]  sa[4];
    logic [2:0]  sop[4];

    alu_pipe #(.WIDTH(8), .SAT(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .op_a(op_a), .op_b(op_b), .alu_op(alu_op), .out_valid(out_valid0),
        .out_ready(out_ready), .result(result0), .flags(flags0),
        .ovf_sticky(sticky0), .clr_sticky(clr_sticky)
    );
    alu_pipe #(.WIDTH(8), .SAT(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .op_a(op_a), .op_b(op_b), .alu_op(alu_op), .out_valid(out_valid1),
        .out_ready(out_ready), .result(result1), .flags(flags1),
        .ovf_sticky(sticky1), .clr_sticky(clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {V,N,Z,C,result}
    function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input bit sat);
        logic [7:0] r;
        bit c, v;
        int s, sh;
        sh = int'(b[2:0]);
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                s = int'(a) + int'(b);
                r = 8'(s);
                c = s > 255;
                s = int'($signed(a)) + int'($signed(b));
                v = s > 127 || s < -128;
                if (sat && c) r = 8'hFF;
            end
            3'd1: begin
                r = a - b;
                c = a < b;
                s = int'($signed(a)) - int'($signed(b));
                v = s > 127 || s < -128;
                if (sat && c) r = 8'h00;
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin
                r = a << sh;
                c = sh != 0 && a[8-sh];
            end
            default: begin
                r = a >> sh;
                c = sh != 0 && a[sh-1];
            end
        endcase
        return {v, r[7], r == 8'h00, c, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input bit ordy, input bit clr);
        logic [23:0] e;
        in_valid = v; op_a = a; op_b = b; alu_op = op; out_ready = ordy; clr_sticky = clr;
        #1;
        acc = int'(v && in_ready0);
        if (acc != 0) sb.push_back({model(a, b, op, 1'b1), model(a, b, op, 1'b0)});
        if (out_valid0 && out_ready) begin
            if (sb.size() == 0) chk("stale_out", 32'(out_valid0), 32'd0);
            else begin
                e = sb.pop_front();
                chk("result", {8'h0, flags1, result1, flags0, result0}, {8'h0, e});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int k;
        acc = 0;
        k = 0;
        while (acc == 0 && k < 10) begin
            cycle(1'b1, a, b, op, 1'b1, 1'b0);
            k++;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 20) begin
            cycle(1'b0, 8'h0, 8'h0, 3'd0, 1'b1, 1'b0);
            k++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        op_a = '0; op_b = '0; alu_op = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", {20'h0, result0, flags0, out_valid0, sticky0}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        // FF+01: carry, latency
        cycle(1'b1, 8'hFF, 8'h01, OP_ADD, 1'b1, 1'b0);
        chk("lat_accept", 32'(acc), 32'd1);
        chk("lat_edge1", 32'(out_valid0), 32'd0);
        cycle(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1, 1'b0);
        chk("lat_edge2", 32'(out_valid0), 32'd1);
        cycle(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1, 1'b0);
        chk("sticky_carry", {30'h0, sticky1, sticky0}, 32'd3);
        cycle(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1, 1'b1);
        chk("sticky_clr1", {30'h0, sticky1, sticky0}, 32'd0);
        // logic ops and SHR carry must not set sticky
        issue(8'hF0, 8'h3C, OP_AND);
        issue(8'hF0, 8'h3C, OP_OR);
        issue(8'hA5, 8'hA5, OP_XOR);
        issue(8'h00, 8'h12, OP_NOT);
        issue(8'h81, 8'h01, OP_SHR);
        drain();
        chk("sticky_logic", {30'h0, sticky1, sticky0}, 32'd0);
        // signed overflow
        issue(8'h7F, 8'h01, OP_ADD);
        drain();
        chk("sticky_ovf", {30'h0, sticky1, sticky0}, 32'd3);
        cycle(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1, 1'b1);
        chk("sticky_clr2", {30'h0, sticky1, sticky0}, 32'd0);
        // clear on the consuming cycle wins
        cycle(1'b1, 8'h7F, 8'h01, OP_ADD, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, OP_ADD, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1, 1'b1);
        chk("sticky_clr_wins", {30'h0, sticky1, sticky0}, 32'd0);
        // arithmetic and shift boundaries
        issue(8'h00, 8'h01, OP_SUB);
        issue(8'h81, 8'h01, OP_SHL);
        issue(8'h81, 8'h09, OP_SHL);
        issue(8'h80, 8'h07, OP_SHR);
        issue(8'h81, 8'h00, OP_SHL);
        issue(8'h05, 8'h05, OP_SUB);
        issue(8'h80, 8'h80, OP_ADD);
        issue(8'h80, 8'h01, OP_SUB);
        drain();
        cycle(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1, 1'b1);
        // stall: out_ready low for 4 cycles
        sa[0] = 8'h11; sa[1] = 8'h22; sa[2] = 8'h33; sa[3] = 8'h44;
        sop[0] = OP_ADD; sop[1] = OP_SUB; sop[2] = OP_XOR; sop[3] = OP_SHL;
        idx = 0;
        held_r = '0; held_f = '0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, sa[idx & 3], 8'h05, sop[idx & 3], 1'b0, 1'b0);
            idx += acc;
            if (i == 1) begin
                held_r = result0;
                held_f = flags0;
            end
        end
        chk("stall_accepted", 32'(idx), 32'd2);
        chk("stall_in_ready", 32'(in_ready0), 32'd0);
        chk("stall_hold", {19'h0, result0, flags0, out_valid0}, {19'h0, held_r, held_f, 1'b1});
        n = 0;
        while (idx < 4 && n < 10) begin
            cycle(1'b1, sa[idx & 3], 8'h05, sop[idx & 3], 1'b1, 1'b0);
            idx += acc;
            n++;
        end
        chk("stall_all_accepted", 32'(idx), 32'd4);
        drain();
        // reset with two operations in flight
        cycle(1'b1, 8'h01, 8'h02, OP_ADD, 1'b0, 1'b0);
        cycle(1'b1, 8'h03, 8'h04, OP_SUB, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", {22'h0, out_valid0, out_valid1, result0}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready0), 32'd1);
        repeat (4) cycle(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1, 1'b0);
        chk("rst_no_stale", 32'(out_valid0), 32'd0);
        // random traffic with random backpressure
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rop = 3'($urandom);
            acc = 0;
            n = 0;
            while (acc == 0 && n < 10) begin
                cycle(1'b1, ra, rb, rop, 1'($urandom_range(0, 1)), 1'b0);
                n++;
            end
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand and result width in bits (legal range 4..64).
REQ-002 SHALL have parameter SAT, default 0; 1 enables unsigned saturating ADD/SUB.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid & in_ready at clk edge
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B, low $clog2(WIDTH) bits are the shift amount
- alu_op  in  3  operation select
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid & out_ready at clk edge
- result  out  WIDTH  operation result
- flags  out  4  {V,N,Z,C} for result
- ovf_sticky  out  1  set by any delivered result with V=1 or with C=1 on ADD/SUB
- clr_sticky  in  1  synchronous clear of ovf_sticky

Function
REQ-004 SHALL decode alu_op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT(~op_a), 110 SHL(op_a << sh), 111 SHR(logical op_a >> sh).
REQ-005 SHALL be a 2-stage pipeline: stage 1 registers operands/opcode; stage 2 registers result/flags; latency exactly 2 cycles from accept edge to out_valid with no stall; throughput 1 op/cycle.
REQ-006 SHALL compute ADD/SUB at WIDTH+1 bits; C = carry out for ADD, borrow (op_a < op_b unsigned) for SUB.
REQ-007 SHALL set V = signed two's-complement overflow for ADD/SUB, 0 for other ops; C = 0 for logic ops; C = last bit shifted out for SHL/SHR (0 when sh=0).
REQ-008 SHALL set Z = (result == 0) and N = result[WIDTH-1], evaluated on the final (possibly saturated) result.
REQ-009 With SAT=1, SHALL clamp ADD with C=1 to all-ones and SUB with C=1 to zero; C and V still report the unsaturated condition.
REQ-010 SHALL advance stage 2 when !out_valid | out_ready; stage 1 advances when stage 2 advances or stage 1 is empty; in_ready = !s1_valid | s1_advance (combinational from out_ready, no bubble).
REQ-011 SHALL hold result, flags, out_valid stable while out_valid & !out_ready.
REQ-012 SHALL deliver results in acceptance order, never dropping or duplicating.
REQ-013 SHALL set ovf_sticky on the cycle a qualifying result is consumed (out_valid & out_ready); clr_sticky on that same cycle wins (sticky reads 0 next cycle).
REQ-014 Operands/opcode SHALL be ignored when in_valid=0; data registers need not update on invalid slots.

Reset
REQ-015 On rst_n low, s1_valid, out_valid, ovf_sticky SHALL clear to 0 immediately; result and flags SHALL reset to 0.
REQ-016 Reset mid-operation SHALL discard all in-flight ops; in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Structure
REQ-017 Opcode encodings, flag bit indices (C=0,Z=1,N=2,V=3) SHALL live in shared package alu_pkg.
REQ-018 Combinational datapath SHALL be sub-module alu_core (WIDTH, SAT parameters; op_a, op_b, alu_op in; result, flags out), instantiated between stage 1 and stage 2 registers.

Verification (WIDTH=8)
REQ-019 ADD 0xFF+0x01, SAT=0 -> result 0x00, flags C=1 Z=1 N=0 V=0, out_valid 2 cycles after accept; SAT=1 -> 0xFF, C=1 Z=0 N=1.
REQ-020 SUB 0x00-0x01, SAT=0 -> 0xFF, C=1 N=1; ADD 0x7F+0x01 -> 0x80, V=1 N=1, ovf_sticky=1 after consume, cleared by clr_sticky pulse.
REQ-021 SHL 0x81 by 1 -> 0x02 C=1; SHR 0x81 by 1 -> 0x40 C=1; SHL op_b=0x09 -> shift 1 (low 3 bits).
REQ-022 Four back-to-back ops with out_ready low 4 cycles -> in_ready drops after 2 accepted, results held stable, all four emerge in order once out_ready=1.
REQ-023 rst_n asserted with 2 ops in flight -> out_valid 0 immediately, no stale result delivered after release.
